// File: rtl/safe_pkg.sv
// -----------------------------------------------------------------------------
// safe_pkg
// Shared definitions for the safe keypad front-end (safe_code_entry) and the
// safe logic that consumes the combination stream.
//   - state_e      : entry FSM states (COLLECT, SEND)
//   - DIGIT_W      : width of one hex key digit
//   - COUNT_W      : width of the buffered-digit counter
//   - MIN/MAX_DIGITS : legal range of the code length
//   - KEY_DIGIT_*  : key-code range shared with the safe logic
// -----------------------------------------------------------------------------
package safe_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned COUNT_W    = 4;
  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [DIGIT_W-1:0] KEY_DIGIT_MIN = 4'h0;
  localparam logic [DIGIT_W-1:0] KEY_DIGIT_MAX = 4'hF;
  localparam logic [DIGIT_W-1:0] COMB_IDLE     = 4'h0;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_e;

endpackage : safe_pkg

// File: rtl/safe_entry_timer.sv
// -----------------------------------------------------------------------------
// safe_entry_timer
// Idle counter that discards a stale partial keypad entry. Only instantiated
// when SAFE_ENTRY_TIMEOUT_EN is defined.
// Ports:
//   clock     in  : rising-edge clock
//   reset     in  : asynchronous active-high reset
//   restart_i in  : a key pulse arrived; count starts over from 0
//   hold_i    in  : nothing to time (SEND or empty buffer); count held at 0
//   expire_o  out : counter reached TIMEOUT_CYCLES-1 this cycle (combinational;
//                   the owner registers the resulting pulse)
// -----------------------------------------------------------------------------
module safe_entry_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart_i,
  input  logic hold_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-count and expiry: hold/restart win over expiry so a key pulse in the
  // expiring cycle keeps the entry alive.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (hold_i || restart_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = {CW{1'b0}};
      expire_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Idle count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : safe_entry_timer

// File: rtl/safe_code_entry.sv
// -----------------------------------------------------------------------------
// safe_code_entry
// Keypad front-end for the digital safe. Collects hex digits into a DIGITS-deep
// buffer and, on ENTER with a full buffer, streams the code first-digit-first
// onto the 4-bit combination bus under a ready/valid handshake.
// Optional feature: define SAFE_ENTRY_TIMEOUT_EN to discard a partial entry
// after TIMEOUT_CYCLES idle cycles; otherwise timeout stays 0.
// Ports:
//   clock, reset       : rising-edge clock, async active-high reset
//   key_valid/key_code : one-cycle digit pulse and its hex value
//   key_enter          : one-cycle pulse, submit the buffered code
//   key_clear          : one-cycle pulse, discard the buffered code
//   comb_ready         : consumer accepts the current digit
//   combination        : current code digit (0 when comb_valid=0)
//   comb_valid         : combination holds a valid digit
//   comb_last          : final digit of the code (qualified by comb_valid)
//   busy               : streaming; key inputs ignored
//   entry_count        : digits buffered, 0..DIGITS
//   overflow           : sticky, a digit arrived with the buffer full
//   entry_error        : one-cycle pulse, ENTER with an incomplete code
//   timeout            : one-cycle pulse, partial entry expired
// All outputs are registered.
// -----------------------------------------------------------------------------
module safe_code_entry
  import safe_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               comb_ready,
  output logic [DIGIT_W-1:0] combination,
  output logic               comb_valid,
  output logic               comb_last,
  output logic               busy,
  output logic [COUNT_W-1:0] entry_count,
  output logic               overflow,
  output logic               entry_error,
  output logic               timeout
);

  localparam int unsigned IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]      LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DIGITS);

  if ((DIGITS < MIN_DIGITS) || (DIGITS > MAX_DIGITS) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("safe_code_entry: DIGITS or TIMEOUT_CYCLES out of range");
  end

  state_e             state_q,   state_d;
  logic [IW-1:0]      idx_q,     idx_d;
  logic [COUNT_W-1:0] count_q,   count_d;
  logic [DIGIT_W-1:0] code_q [DIGITS];
  logic [DIGIT_W-1:0] code_d [DIGITS];
  logic [DIGIT_W-1:0] comb_q,    comb_d;
  logic               valid_q,   valid_d;
  logic               last_q,    last_d;
  logic               busy_q,    busy_d;
  logic               ovf_q,     ovf_d;
  logic               err_q,     err_d;
  logic               tmo_q,     tmo_d;

  logic [IW-1:0]      idx_next_s;
  logic               expire_s;

  assign idx_next_s = idx_q + IW'(1);

`ifdef SAFE_ENTRY_TIMEOUT_EN
  logic restart_s;
  logic hold_s;

  assign restart_s = key_valid | key_enter | key_clear;
  assign hold_s    = (state_q != COLLECT) || (count_q == {COUNT_W{1'b0}});

  safe_entry_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .restart_i (restart_s),
    .hold_i    (hold_s),
    .expire_o  (expire_s)
  );
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next-output logic for the COLLECT/SEND FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    code_d  = code_q;
    comb_d  = comb_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    tmo_d   = 1'b0;

    case (state_q)
      COLLECT: begin
        comb_d  = COMB_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (key_clear) begin
          count_d = {COUNT_W{1'b0}};
          ovf_d   = 1'b0;
        end else if (key_enter) begin
          if (count_q == FULL_COUNT) begin
            // Present the first digit right away so it is valid the cycle
            // after ENTER; DIGITS >= 2 means it is never the last one.
            state_d = SEND;
            idx_d   = {IW{1'b0}};
            comb_d  = code_q[0];
            valid_d = 1'b1;
            last_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            count_d = {COUNT_W{1'b0}};
            ovf_d   = 1'b0;
          end
        end else if (key_valid) begin
          if (count_q < FULL_COUNT) begin
            code_d[count_q[IW-1:0]] = key_code;
            count_d                 = count_q + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (expire_s) begin
          // The timer never expires in a cycle carrying a key pulse.
          count_d = {COUNT_W{1'b0}};
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          count_d = count_q;
        end
      end

      SEND: begin
        if (valid_q && comb_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = COLLECT;
            idx_d   = {IW{1'b0}};
            count_d = {COUNT_W{1'b0}};
            ovf_d   = 1'b0;
            comb_d  = COMB_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            idx_d  = idx_next_s;
            comb_d = code_q[idx_next_s];
            last_d = (idx_next_s == LAST_IDX);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      default: begin
        state_d = COLLECT;
        idx_d   = {IW{1'b0}};
        count_d = {COUNT_W{1'b0}};
        ovf_d   = 1'b0;
        comb_d  = COMB_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, buffer and output registers; reset also wipes the stored code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= {IW{1'b0}};
      count_q <= {COUNT_W{1'b0}};
      for (int i = 0; i < int'(DIGITS); i++) begin
        code_q[i] <= {DIGIT_W{1'b0}};
      end
      comb_q  <= COMB_IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      code_q  <= code_d;
      comb_q  <= comb_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign combination = comb_q;
  assign comb_valid  = valid_q;
  assign comb_last   = last_q;
  assign busy        = busy_q;
  assign entry_count = count_q;
  assign overflow    = ovf_q;
  assign entry_error = err_q;
  assign timeout     = tmo_q;

endmodule : safe_code_entry

// File: tb/tb_safe_code_entry.sv
// -----------------------------------------------------------------------------
// tb_safe_code_entry
// Self-checking bench for safe_code_entry (DIGITS=4, TIMEOUT_CYCLES=8).
// A queue-based reference model tracks the entered code, the code being
// streamed, the sticky overflow and (timeout build) the idle time, and predicts
// every output after each clock edge. Directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_safe_code_entry;

  localparam int DIGITS = 4;
  localparam int TCYC   = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid, key_enter, key_clear, comb_ready;
  logic [3:0] key_code;
  logic [3:0] combination, entry_count;
  logic       comb_valid, comb_last, busy, overflow, entry_error, timeout;

  always #5 clock = ~clock;

  safe_code_entry #(
    .DIGITS         (DIGITS),
    .TIMEOUT_CYCLES (TCYC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .comb_ready  (comb_ready),
    .combination (combination),
    .comb_valid  (comb_valid),
    .comb_last   (comb_last),
    .busy        (busy),
    .entry_count (entry_count),
    .overflow    (overflow),
    .entry_error (entry_error),
    .timeout     (timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Packed view: {combination, valid, last, busy, count, overflow, error, timeout}
  wire  [13:0] obs_vec = {combination, comb_valid, comb_last, busy, entry_count,
                          overflow, entry_error, timeout};
  logic [13:0] exp_vec;

  // Reference model state
  logic [3:0] m_entered[$];
  logic [3:0] m_sending[$];
  bit         m_send, m_ovf, m_err, m_to;
  int         m_idle;

  function automatic logic [13:0] pack(logic [3:0] c, logic v, logic l, logic b,
                                       logic [3:0] n, logic o, logic e, logic t);
    return {c, v, l, b, n, o, e, t};
  endfunction

  task automatic model_expect();
    logic [3:0] c;
    c = 4'h0;
    if (m_send) c = m_sending[0];
    exp_vec = pack(c, m_send, m_send && (m_sending.size() == 1), m_send,
                   4'(m_entered.size()), m_ovf, m_err, m_to);
  endtask

  task automatic model_reset();
    m_entered.delete();
    m_sending.delete();
    m_send = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_to = 1'b0; m_idle = 0;
    model_expect();
  endtask

  // Drive one cycle of inputs, advance one clock edge, update the model.
  task automatic step(input bit clr, input bit ent, input bit val,
                      input logic [3:0] code, input bit rdy);
    bit anykey, expire;
    key_clear = clr; key_enter = ent; key_valid = val; key_code = code; comb_ready = rdy;
    @(posedge clock); #1;
    key_clear = 1'b0; key_enter = 1'b0; key_valid = 1'b0;
    anykey = clr | ent | val;
    m_err = 1'b0; m_to = 1'b0;
`ifdef SAFE_ENTRY_TIMEOUT_EN
    expire = !m_send && (m_entered.size() > 0) && !anykey && (m_idle == TCYC - 1);
    if (m_send || (m_entered.size() == 0) || anykey || expire) m_idle = 0;
    else m_idle++;
`else
    expire = 1'b0;
`endif
    if (m_send) begin
      if (rdy) begin
        void'(m_sending.pop_front());
        if (m_sending.size() == 0) begin
          m_send = 1'b0; m_entered.delete(); m_ovf = 1'b0;
        end
      end
    end else if (clr) begin
      m_entered.delete(); m_ovf = 1'b0;
    end else if (ent) begin
      if (m_entered.size() == DIGITS) begin
        m_sending = m_entered; m_send = 1'b1;
      end else begin
        m_err = 1'b1; m_entered.delete(); m_ovf = 1'b0;
      end
    end else if (val) begin
      if (m_entered.size() < DIGITS) m_entered.push_back(code);
      else m_ovf = 1'b1;
    end else if (expire) begin
      m_entered.delete(); m_ovf = 1'b0; m_to = 1'b1;
    end
    model_expect();
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    key_code = 4'h0; comb_ready = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (obs_vec !== 14'h0) begin
      $display("FAIL reset_state: got %h expected %h", obs_vec, 14'h0); miscompares++;
    end
    @(negedge clock); reset = 1'b0;
    model_reset();
    @(posedge clock); #1;
    vectors++;
    if (obs_vec !== exp_vec) begin
      $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec); miscompares++;
    end
  endtask

  task automatic test_basic();
    logic [3:0] code [4];
    code = '{4'h7, 4'h5, 4'hB, 4'hA};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, code[i], 1'b1);
    vectors++;
    if (entry_count !== 4'd4) begin
      $display("FAIL basic_count: got %0d expected 4", entry_count); miscompares++;
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({combination, comb_valid, comb_last, busy} !== {code[i], 1'b1, 1'(i == 3), 1'b1}) begin
        $display("FAIL basic_beat%0d: got %h/%b/%b expected %h/1/%b", i, combination,
                 comb_valid, comb_last, code[i], i == 3);
        miscompares++;
      end
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL basic_model%0d: got %h expected %h", i, obs_vec, exp_vec); miscompares++;
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    end
    vectors++;
    if ({busy, comb_valid, combination, entry_count} !== 10'h0) begin
      $display("FAIL basic_done: got busy=%b valid=%b comb=%h count=%0d expected all 0",
               busy, comb_valid, combination, entry_count);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] code [4];
    logic [3:0] expc [7];
    bit         rdy  [7];
    code = '{4'h7, 4'h5, 4'hB, 4'hA};
    expc = '{4'h7, 4'h5, 4'h5, 4'h5, 4'h5, 4'hB, 4'hA};
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, code[i], 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int j = 0; j < 7; j++) begin
      vectors++;
      if ({combination, comb_valid, comb_last} !== {expc[j], 1'b1, 1'(j == 6)}) begin
        $display("FAIL stall_beat%0d: got %h/%b/%b expected %h/1/%b", j, combination,
                 comb_valid, comb_last, expc[j], j == 6);
        miscompares++;
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, rdy[j]);
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL stall_model%0d: got %h expected %h", j, obs_vec, exp_vec); miscompares++;
      end
    end
  endtask

  task automatic test_short_entry();
    step(1'b0, 1'b0, 1'b1, 4'h3, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'h1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    vectors++;
    if ({entry_error, entry_count, comb_valid, busy} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      $display("FAIL short_enter: got err=%b count=%0d valid=%b expected 1/0/0",
               entry_error, entry_count, comb_valid);
      miscompares++;
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    vectors++;
    if ({entry_error, comb_valid} !== 2'b00) begin
      $display("FAIL short_pulse: got err=%b valid=%b expected 0/0", entry_error, comb_valid);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0] keys [5];
    keys = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9};
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, keys[i], 1'b1);
    vectors++;
    if ({overflow, entry_count} !== {1'b1, 4'd4}) begin
      $display("FAIL ovf_set: got ovf=%b count=%0d expected 1/4", overflow, entry_count);
      miscompares++;
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (combination !== keys[i] || obs_vec !== exp_vec) begin
        $display("FAIL ovf_beat%0d: got %h (%h) expected %h (%h)", i, combination, obs_vec,
                 keys[i], exp_vec);
        miscompares++;
      end
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    end
    vectors++;
    if ({overflow, comb_valid} !== 2'b00) begin
      $display("FAIL ovf_clear: got ovf=%b valid=%b expected 0/0", overflow, comb_valid);
      miscompares++;
    end
  endtask

  task automatic test_clear_enter_and_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 6), 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    vectors++;
    if ({entry_count, comb_valid, busy, entry_error} !== 7'h0) begin
      $display("FAIL clear_vs_enter: got count=%0d valid=%b busy=%b err=%b expected all 0",
               entry_count, comb_valid, busy, entry_error);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 12), 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    vectors++;
    if ({combination, comb_valid} !== {4'hE, 1'b1}) begin
      $display("FAIL reset_pre: got %h/%b expected e/1", combination, comb_valid);
      miscompares++;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 14'h0) begin
      $display("FAIL reset_midsend: got %h expected %h", obs_vec, 14'h0); miscompares++;
    end
    @(negedge clock); reset = 1'b0;
    model_reset();
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    vectors++;
    if (obs_vec !== exp_vec) begin
      $display("FAIL reset_no_code: got %h expected %h", obs_vec, exp_vec); miscompares++;
    end
  endtask

  task automatic test_random();
    bit c, e, v, r;
    logic [3:0] k;
    for (int i = 0; i < 2000; i++) begin
      c = ($urandom_range(0, 19) == 0);
      e = (m_entered.size() == DIGITS) ? ($urandom_range(0, 2) == 0)
                                       : ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 2) != 0);
      k = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) begin
        repeat ($urandom_range(1, 12)) begin
          step(1'b0, 1'b0, 1'b0, 4'h0, r);
          vectors++;
          if (obs_vec !== exp_vec) begin
            $display("FAIL random_idle: got %h expected %h", obs_vec, exp_vec); miscompares++;
          end
        end
      end
      step(c, e, v, k, r);
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL random_%0d: got %h expected %h", i, obs_vec, exp_vec); miscompares++;
      end
    end
  endtask

`ifdef SAFE_ENTRY_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 4'h6, 1'b1);
    pulses = 0;
    for (int i = 0; i < TCYC; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      if (timeout) pulses++;
      vectors++;
      if (obs_vec !== exp_vec) begin
        $display("FAIL timeout_idle%0d: got %h expected %h", i, obs_vec, exp_vec); miscompares++;
      end
    end
    vectors++;
    if (pulses != 1 || entry_count !== 4'd0) begin
      $display("FAIL timeout_expire: got pulses=%0d count=%0d expected 1/0", pulses, entry_count);
      miscompares++;
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, (i % 5) == 0, 4'h2, 1'b1);
      if (timeout) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      $display("FAIL timeout_keepalive: got pulses=%0d expected 0", pulses); miscompares++;
    end
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_entry();
    test_overflow();
    test_clear_enter_and_reset();
`ifdef SAFE_ENTRY_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_safe_code_entry
